// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and field helper
// for the UART "HH:MM:SS" time-set command parser.
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  localparam logic [7:0] ACK_OK  = 8'h4B;
  localparam logic [7:0] ACK_ERR = 8'h3F;

  localparam logic [6:0] HOUR_MAX   = 7'd23;
  localparam logic [6:0] MINSEC_MAX = 7'd59;

  typedef enum logic [1:0] {
    S_RECV,
    S_WAIT_EOL,
    S_DISCARD,
    S_ACK
  } state_e;

  function automatic logic [6:0] field_val(
    input logic [3:0] tens,
    input logic [3:0] ones
  );
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

endpackage

// File: rtl/uart_time_parser_if.sv
// Bundle of the parser's UART-side and time-side signals.
// The parser drives the dut side; a host or bench drives the tb side.
interface uart_time_parser_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_busy;
  logic [7:0] tx_data;
  logic       tx_send;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic       set_time;
  logic       cmd_err;

  modport dut (
    input  rx_data, rx_valid, tx_busy,
    output tx_data, tx_send, hour, minute,
    output second, set_time, cmd_err
  );

  modport tb (
    output rx_data, rx_valid, tx_busy,
    input  tx_data, tx_send, hour, minute,
    input  second, set_time, cmd_err
  );

endinterface

// File: rtl/byte_timeout.sv
// Inter-byte idle timer: strobes once after TIMEOUT_CYCLES
// enabled cycles without a clear.
module byte_timeout #(
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    timeout = 1'b0;
    if (clear || !enable) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d   = '0;
      timeout = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_time_parser.sv
// Parses "HH:MM:SS\n" lines from a UART receiver, publishes the
// time on success and answers 'K' or '?' through the UART transmitter.
module uart_time_parser
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_send,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       set_time,
  output logic       cmd_err
);

  state_e          state_q, state_d;
  logic [2:0]      pos_q, pos_d;
  logic [5:0][3:0] dig_q, dig_d;
  logic [4:0]      hour_q, hour_d;
  logic [5:0]      minute_q, minute_d;
  logic [5:0]      second_q, second_d;
  logic            set_time_q, set_time_d;
  logic            cmd_err_q, cmd_err_d;
  logic            tx_send_q, tx_send_d;
  logic [7:0]      tx_data_q, tx_data_d;

  logic       tmo, tmo_en;
  logic       byte_v, is_lf, is_digit, is_colon, want_colon;
  logic       in_range;
  logic [6:0] hr_v, mn_v, sc_v;

  assign tmo_en = (state_q == S_RECV && pos_q != 3'd0)
               || state_q == S_WAIT_EOL
               || state_q == S_DISCARD;

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_valid),
    .enable (tmo_en),
    .timeout(tmo)
  );

  assign byte_v     = rx_valid && rx_data != ASCII_CR;
  assign is_lf      = rx_data == ASCII_LF;
  assign is_digit   = rx_data >= ASCII_0 && rx_data <= ASCII_9;
  assign is_colon   = rx_data == ASCII_COLON;
  assign want_colon = pos_q == 3'd2 || pos_q == 3'd5;

  // Digits shift in MSB-first: [5:4] hour, [3:2] minute, [1:0] second.
  assign hr_v     = field_val(dig_q[5], dig_q[4]);
  assign mn_v     = field_val(dig_q[3], dig_q[2]);
  assign sc_v     = field_val(dig_q[1], dig_q[0]);
  assign in_range = hr_v <= HOUR_MAX && mn_v <= MINSEC_MAX
                 && sc_v <= MINSEC_MAX;

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    dig_d      = dig_q;
    hour_d     = hour_q;
    minute_d   = minute_q;
    second_d   = second_q;
    set_time_d = 1'b0;
    cmd_err_d  = 1'b0;
    tx_send_d  = 1'b0;
    tx_data_d  = tx_data_q;
    unique case (state_q)
      S_RECV: begin
        if (tmo) begin
          pos_d = 3'd0;
        end else if (byte_v && is_lf) begin
          if (pos_q != 3'd0) begin
            cmd_err_d = 1'b1;
            tx_data_d = ACK_ERR;
            state_d   = S_ACK;
            pos_d     = 3'd0;
          end
        end else if (byte_v) begin
          if (want_colon ? is_colon : is_digit) begin
            if (!want_colon) dig_d = {dig_q[4:0], rx_data[3:0]};
            pos_d = pos_q + 3'd1;
            if (pos_q == 3'd7) state_d = S_WAIT_EOL;
          end else begin
            state_d = S_DISCARD;
            pos_d   = 3'd0;
          end
        end
      end
      S_WAIT_EOL: begin
        if (tmo) begin
          state_d = S_RECV;
        end else if (byte_v && is_lf && in_range) begin
          hour_d     = hr_v[4:0];
          minute_d   = mn_v[5:0];
          second_d   = sc_v[5:0];
          set_time_d = 1'b1;
          tx_data_d  = ACK_OK;
          state_d    = S_ACK;
        end else if (byte_v && is_lf) begin
          cmd_err_d = 1'b1;
          tx_data_d = ACK_ERR;
          state_d   = S_ACK;
        end else if (byte_v) begin
          state_d = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (tmo) begin
          state_d = S_RECV;
        end else if (byte_v && is_lf) begin
          cmd_err_d = 1'b1;
          tx_data_d = ACK_ERR;
          state_d   = S_ACK;
        end
      end
      S_ACK: begin
        if (!tx_busy && !tx_send_q) begin
          tx_send_d = 1'b1;
          state_d   = S_RECV;
          pos_d     = 3'd0;
        end
      end
      default: state_d = S_RECV;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RECV;
      pos_q      <= 3'd0;
      dig_q      <= '0;
      hour_q     <= '0;
      minute_q   <= '0;
      second_q   <= '0;
      set_time_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      tx_send_q  <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      dig_q      <= dig_d;
      hour_q     <= hour_d;
      minute_q   <= minute_d;
      second_q   <= second_d;
      set_time_q <= set_time_d;
      cmd_err_q  <= cmd_err_d;
      tx_send_q  <= tx_send_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign hour     = hour_q;
  assign minute   = minute_q;
  assign second   = second_q;
  assign set_time = set_time_q;
  assign cmd_err  = cmd_err_q;
  assign tx_send  = tx_send_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_time_parser.sv
// Directed bench for uart_time_parser: good, bad, timed-out,
// busy-stalled and reset-interrupted command lines.
module tb_uart_time_parser;

  logic clk;
  logic reset;

  uart_time_parser_if u_if();

  uart_time_parser #(
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rx_data (u_if.rx_data),
    .rx_valid(u_if.rx_valid),
    .tx_busy (u_if.tx_busy),
    .tx_data (u_if.tx_data),
    .tx_send (u_if.tx_send),
    .hour    (u_if.hour),
    .minute  (u_if.minute),
    .second  (u_if.second),
    .set_time(u_if.set_time),
    .cmd_err (u_if.cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int st_cnt = 0;
  int err_cnt = 0;
  int ts_cnt = 0;
  int both_cnt = 0;
  logic [7:0] last_tx = 8'h00;

  int b_st, b_err, b_ts;

  always @(negedge clk) begin
    if (u_if.set_time) st_cnt++;
    if (u_if.cmd_err) err_cnt++;
    if (u_if.set_time && u_if.cmd_err) both_cnt++;
    if (u_if.tx_send) begin
      ts_cnt++;
      last_tx = u_if.tx_data;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat (9) @(posedge clk);
    #1;
    u_if.rx_data  = b;
    u_if.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    u_if.rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic mark();
    b_st  = st_cnt;
    b_err = err_cnt;
    b_ts  = ts_cnt;
  endtask

  task automatic chk_time(input string tag,
                          input int h, input int m, input int s);
    chk({tag, "_hour"}, 32'(u_if.hour), h);
    chk({tag, "_min"},  32'(u_if.minute), m);
    chk({tag, "_sec"},  32'(u_if.second), s);
  endtask

  initial begin
    reset         = 1'b0;
    u_if.rx_data  = 8'h00;
    u_if.rx_valid = 1'b0;
    u_if.tx_busy  = 1'b0;
    settle(4);
    chk_time("rst", 0, 0, 0);
    chk("rst_txd", 32'(u_if.tx_data), 32'h00);
    chk("rst_st",  32'(u_if.set_time), 0);
    chk("rst_err", 32'(u_if.cmd_err), 0);
    chk("rst_ts",  32'(u_if.tx_send), 0);
    reset = 1'b1;
    settle(2);

    // good line with precise strobe timing
    mark();
    send_str("12:34:56");
    send_byte(8'h0A);
    chk("ok_st_pulse", 32'(u_if.set_time), 1);
    chk("ok_err_low",  32'(u_if.cmd_err), 0);
    chk_time("ok", 12, 34, 56);
    chk("ok_ts_early", 32'(u_if.tx_send), 0);
    settle(1);
    chk("ok_st_gone", 32'(u_if.set_time), 0);
    chk("ok_ts",      32'(u_if.tx_send), 1);
    chk("ok_txd",     32'(u_if.tx_data), 32'h4B);
    settle(1);
    chk("ok_ts_gone", 32'(u_if.tx_send), 0);
    settle(5);
    chk("ok_ts_cnt", 32'(ts_cnt - b_ts), 1);
    chk("ok_st_cnt", 32'(st_cnt - b_st), 1);

    // hour out of range, CR ignored
    mark();
    send_str("24:00:00\r\n");
    chk("rng_err_pulse", 32'(u_if.cmd_err), 1);
    chk("rng_st_low",    32'(u_if.set_time), 0);
    settle(5);
    chk_time("rng", 12, 34, 56);
    chk("rng_err_cnt", 32'(err_cnt - b_err), 1);
    chk("rng_st_cnt",  32'(st_cnt - b_st), 0);
    chk("rng_ts_cnt",  32'(ts_cnt - b_ts), 1);
    chk("rng_ack",     32'(last_tx), 32'h3F);

    // bad digit, then boundary-max time
    mark();
    send_str("1a:00:00\n");
    settle(5);
    chk("bad_err_cnt", 32'(err_cnt - b_err), 1);
    chk("bad_ack",     32'(last_tx), 32'h3F);
    chk_time("bad", 12, 34, 56);
    send_str("23:59:59\n");
    settle(5);
    chk("max_st_cnt",  32'(st_cnt - b_st), 1);
    chk("max_err_cnt", 32'(err_cnt - b_err), 1);
    chk("max_ack",     32'(last_tx), 32'h4B);
    chk_time("max", 23, 59, 59);

    // empty line is silent; extra char before LF is an error
    mark();
    send_byte(8'h0A);
    settle(5);
    chk("empty_st",  32'(st_cnt - b_st), 0);
    chk("empty_err", 32'(err_cnt - b_err), 0);
    chk("empty_ts",  32'(ts_cnt - b_ts), 0);
    send_str("12:34:567\n");
    settle(5);
    chk("long_err", 32'(err_cnt - b_err), 1);
    chk("long_ack", 32'(last_tx), 32'h3F);
    chk_time("long", 23, 59, 59);

    // fragment then idle past the timeout
    mark();
    send_str("12:3");
    settle(80);
    chk("tmo_silent_ts",  32'(ts_cnt - b_ts), 0);
    chk("tmo_silent_err", 32'(err_cnt - b_err), 0);
    send_str("01:02:03\n");
    settle(5);
    chk("tmo_st_cnt",  32'(st_cnt - b_st), 1);
    chk("tmo_err_cnt", 32'(err_cnt - b_err), 0);
    chk_time("tmo", 1, 2, 3);

    // ack held off by tx_busy; bytes during ACK dropped
    mark();
    u_if.tx_busy = 1'b1;
    send_str("07:08:09\n");
    settle(2);
    chk("busy_st_cnt", 32'(st_cnt - b_st), 1);
    send_str("12:00:00\n");
    settle(100);
    chk("busy_ts_cnt", 32'(ts_cnt - b_ts), 0);
    chk("busy_ts_low", 32'(u_if.tx_send), 0);
    chk("busy_st_hold", 32'(st_cnt - b_st), 1);
    chk("busy_err", 32'(err_cnt - b_err), 0);
    u_if.tx_busy = 1'b0;
    #1;
    chk("busy_ts_same", 32'(u_if.tx_send), 0);
    settle(1);
    chk("busy_ts_rise", 32'(u_if.tx_send), 1);
    chk("busy_txd",     32'(u_if.tx_data), 32'h4B);
    settle(5);
    chk("busy_ts_cnt2", 32'(ts_cnt - b_ts), 1);
    chk_time("busy", 7, 8, 9);

    // reset in the middle of a line
    mark();
    send_str("12:3");
    settle(3);
    reset = 1'b0;
    #1;
    chk_time("mid_rst", 0, 0, 0);
    chk("mid_rst_txd", 32'(u_if.tx_data), 32'h00);
    settle(4);
    reset = 1'b1;
    chk("mid_rst_st", 32'(st_cnt - b_st), 0);
    chk("mid_rst_err", 32'(err_cnt - b_err), 0);
    chk("mid_rst_ts", 32'(ts_cnt - b_ts), 0);
    send_str("00:00:01\n");
    settle(5);
    chk("post_rst_st",  32'(st_cnt - b_st), 1);
    chk("post_rst_err", 32'(err_cnt - b_err), 0);
    chk("post_rst_ack", 32'(last_tx), 32'h4B);
    chk_time("post_rst", 0, 0, 1);

    chk("never_both", 32'(both_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
